// File: rtl/ad9826_init_seq.sv
`default_nettype none
// ============================================================================
// Module   : ad9826_init_seq
// Function : Holds a 9-bit image per AD9826 register and plays it into the
//            serial-config engine as 16-bit frames over toggle/busy.
//            Optional per-register readback check: define AD9826_READBACK_EN.
// Revision : 1.0  initial release
// ============================================================================
module ad9826_init_seq #(
    parameter int NUM_REGS       = 8,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int AUTO_START     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tbl_we,
    input  logic [2:0]  tbl_addr,
    input  logic [8:0]  tbl_wdata,
    input  logic        start,
    output logic        seq_busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  err_addr,
    output logic [15:0] ad_config_in,
    output logic        toggle,
    input  logic        busy,
    input  logic [15:0] ad_config_out,
    input  logic        config_out_avail,
    output logic        config_out_recieved
);

    localparam logic [2:0]         c_last_idx = 3'(NUM_REGS - 1);
    localparam int                 c_tmo_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRAIN = 3'd1,
        S_LOAD  = 3'd2,
        S_REQ   = 3'd3,
        S_WAIT  = 3'd4,
        S_ACK   = 3'd5,
        S_NEXT  = 3'd6
    } state_t;

    state_t             r_state;
    logic [2:0]         r_idx;
    logic               r_rw;
    logic               r_auto;
    logic [c_tmo_w-1:0] r_tmo;
    logic [8:0]         r_tbl [8];
    logic               r_busy_m;
    logic               r_busy_s;
    logic               w_tmo_hit;
    logic               w_unused;

    // Synchronisers are deliberately not reset: after a reset mid-frame the
    // engine's busy must be visible to DRAIN on the very first cycle.
    always_ff @(posedge clk) begin
        r_busy_m <= busy;
        r_busy_s <= r_busy_m;
    end

`ifdef AD9826_READBACK_EN
    logic r_avail_m;
    logic r_avail_s;
    logic r_rcvd;

    always_ff @(posedge clk) begin
        r_avail_m <= config_out_avail;
        r_avail_s <= r_avail_m;
    end

    assign config_out_recieved = r_rcvd;
    assign w_unused            = ^ad_config_out[15:9];
`else
    assign config_out_recieved = 1'b0;
    assign w_unused            = ^{ad_config_out, config_out_avail};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) r_tbl[i] <= '0;
        end else if (tbl_we && !seq_busy) begin
            r_tbl[tbl_addr] <= tbl_wdata;
        end
    end

    assign w_tmo_hit = (r_tmo == c_tmo_last) &&
                       (r_state == S_DRAIN || r_state == S_REQ ||
                        r_state == S_WAIT  || r_state == S_ACK);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_rw         <= 1'b0;
            r_auto       <= (AUTO_START != 0);
            r_tmo        <= '0;
            seq_busy     <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            err_addr     <= '0;
            ad_config_in <= '0;
            toggle       <= 1'b0;
`ifdef AD9826_READBACK_EN
            r_rcvd       <= 1'b0;
`endif
        end else begin
            done  <= 1'b0;
            r_tmo <= r_tmo + 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_tmo <= '0;
                    if (start || r_auto) begin
                        r_auto   <= 1'b0;
                        r_idx    <= '0;
                        r_rw     <= 1'b0;
                        err      <= 1'b0;
                        seq_busy <= 1'b1;
                        r_state  <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!r_busy_s) r_state <= S_LOAD;
                end
                S_LOAD: begin
                    ad_config_in <= {r_rw, r_idx, 3'b000, r_tbl[r_idx]};
                    r_tmo        <= '0;
                    r_state      <= S_REQ;
                end
                S_REQ: begin
                    // Holding toggle until busy is seen guarantees it spans a slow-clock edge.
                    if (r_busy_s) begin
                        toggle  <= 1'b0;
                        r_tmo   <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        toggle  <= 1'b1;
                    end
                end
                S_WAIT: begin
`ifdef AD9826_READBACK_EN
                    if (r_rw) begin
                        if (r_avail_s) begin
                            if (ad_config_out[8:0] != r_tbl[r_idx]) begin
                                err      <= 1'b1;
                                err_addr <= r_idx;
                            end
                            r_rcvd  <= 1'b1;
                            r_tmo   <= '0;
                            r_state <= S_ACK;
                        end
                    end else
`endif
                    if (!r_busy_s) r_state <= S_NEXT;
                end
`ifdef AD9826_READBACK_EN
                S_ACK: begin
                    if (!r_busy_s) begin
                        r_rcvd  <= 1'b0;
                        r_state <= S_NEXT;
                    end
                end
`endif
                S_NEXT: begin
`ifdef AD9826_READBACK_EN
                    if (!r_rw) begin
                        r_rw    <= 1'b1;
                        r_state <= S_LOAD;
                    end else
`endif
                    begin
                        r_rw <= 1'b0;
                        if (r_idx == c_last_idx) begin
                            seq_busy <= 1'b0;
                            done     <= 1'b1;
                            r_state  <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_LOAD;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // A stalled handshake abandons the run without a done pulse.
            if (w_tmo_hit) begin
                err      <= 1'b1;
                err_addr <= r_idx;
                toggle   <= 1'b0;
                seq_busy <= 1'b0;
                r_tmo    <= '0;
                r_state  <= S_IDLE;
`ifdef AD9826_READBACK_EN
                r_rcvd   <= 1'b0;
`endif
            end
        end
    end

endmodule
`default_nettype wire
